// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the write-back stage: load funct3 encodings, default
// pending-load depth, write source tags and the optional load extension helper.
package writeback_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int DEFAULT_LOAD_FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_ALU  = 3'd1,
        SRC_FIFO = 3'd2,
        SRC_LOAD = 3'd3,
        SRC_MD   = 3'd4
    } wb_src_e;

`ifdef WB_LOAD_EXTEND_EN
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   load_extend = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_extend = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_extend = {24'd0, byte_sel};
            F3_LHU:  load_extend = {16'd0, half_sel};
            default: load_extend = word;
        endcase
    endfunction
`endif

endpackage

// File: rtl/wb_load_fifo.sv
// Pending-load buffer holding {rd, final data}; supports push and pop in the
// same cycle. A push while full is ignored unless a pop frees the head slot.
module wb_load_fifo #(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [4:0]    push_rd,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [4:0]    head_rd,
    output logic [31:0]   head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_rd   = mem[rd_ptr][36:32];
    assign head_data = mem[rd_ptr][31:0];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= {push_rd, push_data};
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: ALU > pending load > bypassed fresh load > mul/div, one
// registered register-file write per cycle. Load extension under WB_LOAD_EXTEND_EN.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int LOAD_FIFO_DEPTH = DEFAULT_LOAD_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        load_valid_i,
    input  logic [4:0]  load_rd_i,
    input  logic [31:0] load_data_i,
    input  logic [2:0]  load_funct3_i,
    input  logic [1:0]  load_offset_i,
    input  logic        md_valid_i,
    input  logic [4:0]  md_rd_i,
    input  logic [31:0] md_data_i,
    output logic        md_ready_o,
    output logic        reg_write_wb_o,
    output logic [4:0]  reg_rd_wb_o,
    output logic [31:0] reg_rd_data_wb_o,
    output logic        stall_wb_o,
    output logic        overflow_err_o
);

    localparam int CW = $clog2(LOAD_FIFO_DEPTH) + 1;

    wb_src_e       src;
    logic [4:0]    win_rd;
    logic [31:0]   win_data;
    logic [31:0]   load_word;
    logic          fifo_push;
    logic          fifo_pop;
    logic          overflow_evt;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

`ifdef WB_LOAD_EXTEND_EN
    assign load_word = load_extend(load_data_i, load_funct3_i, load_offset_i);
`else
    logic unused_load_sel;
    assign unused_load_sel = ^{load_funct3_i, load_offset_i};
    assign load_word       = load_data_i;
`endif

    always_comb begin
        src          = SRC_NONE;
        win_rd       = '0;
        win_data     = '0;
        fifo_pop     = 1'b0;
        fifo_push    = 1'b0;
        overflow_evt = 1'b0;
        if (!rst_i) begin
            if (alu_valid_i) begin
                src      = SRC_ALU;
                win_rd   = alu_rd_i;
                win_data = alu_data_i;
            end else if (!fifo_empty) begin
                src      = SRC_FIFO;
                win_rd   = head_rd;
                win_data = head_data;
                fifo_pop = 1'b1;
            end else if (load_valid_i) begin
                src      = SRC_LOAD;
                win_rd   = load_rd_i;
                win_data = load_word;
            end else if (md_valid_i) begin
                src      = SRC_MD;
                win_rd   = md_rd_i;
                win_data = md_data_i;
            end
            // A losing load must be buffered; it is lost only when no slot frees up.
            fifo_push    = load_valid_i && (src != SRC_LOAD);
            overflow_evt = fifo_push && fifo_full && !fifo_pop;
        end
    end

    assign md_ready_o = !rst_i && !alu_valid_i && fifo_empty && !load_valid_i;
    assign stall_wb_o = (fifo_count >= CW'(LOAD_FIFO_DEPTH - 1));

    wb_load_fifo #(.DEPTH(LOAD_FIFO_DEPTH)) u_load_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (fifo_push),
        .push_rd   (load_rd_i),
        .push_data (load_word),
        .pop       (fifo_pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_write_wb_o   <= 1'b0;
            reg_rd_wb_o      <= '0;
            reg_rd_data_wb_o <= '0;
            overflow_err_o   <= 1'b0;
        end else begin
            // x0 winners are consumed without a write strobe.
            reg_write_wb_o <= (src != SRC_NONE) && (win_rd != 5'd0);
            if (src != SRC_NONE) begin
                reg_rd_wb_o      <= win_rd;
                reg_rd_data_wb_o <= win_data;
            end
            if (overflow_evt) overflow_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: a queue-based reference model pushes the expected
// write-port value each driven cycle and pops/compares it after the clock edge.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        load_valid_i;
    logic [4:0]  load_rd_i;
    logic [31:0] load_data_i;
    logic [2:0]  load_funct3_i;
    logic [1:0]  load_offset_i;
    logic        md_valid_i;
    logic [4:0]  md_rd_i;
    logic [31:0] md_data_i;
    logic        md_ready_o;
    logic        reg_write_wb_o;
    logic [4:0]  reg_rd_wb_o;
    logic [31:0] reg_rd_data_wb_o;
    logic        stall_wb_o;
    logic        overflow_err_o;

    int checks = 0;
    int errors = 0;

    logic [37:0] exp_q[$];
    logic [36:0] m_fifo[$];
    logic        m_ovf;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    writeback_arbiter #(.LOAD_FIFO_DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .alu_valid_i      (alu_valid_i),
        .alu_rd_i         (alu_rd_i),
        .alu_data_i       (alu_data_i),
        .load_valid_i     (load_valid_i),
        .load_rd_i        (load_rd_i),
        .load_data_i      (load_data_i),
        .load_funct3_i    (load_funct3_i),
        .load_offset_i    (load_offset_i),
        .md_valid_i       (md_valid_i),
        .md_rd_i          (md_rd_i),
        .md_data_i        (md_data_i),
        .md_ready_o       (md_ready_o),
        .reg_write_wb_o   (reg_write_wb_o),
        .reg_rd_wb_o      (reg_rd_wb_o),
        .reg_rd_data_wb_o (reg_rd_data_wb_o),
        .stall_wb_o       (stall_wb_o),
        .overflow_err_o   (overflow_err_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> (off * 8);
        r  = w;
`ifdef WB_LOAD_EXTEND_EN
        case (f3)
            3'b000: r = {{24{sh[7]}}, sh[7:0]};
            3'b100: r = {24'd0, sh[7:0]};
            3'b001: r = off[1] ? {{16{w[31]}}, w[31:16]} : {{16{w[15]}}, w[15:0]};
            3'b101: r = off[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
            default: r = w;
        endcase
`endif
        return r;
    endfunction

    task automatic step(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [2:0] f3, input logic [1:0] off,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        logic        win;
        logic        bypass;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [31:0] lw;
        logic [37:0] e;
        rst_i = rst;
        alu_valid_i = av;  alu_rd_i = ard;  alu_data_i = ad;
        load_valid_i = lv; load_rd_i = lrd; load_data_i = ld;
        load_funct3_i = f3; load_offset_i = off;
        md_valid_i = mv;   md_rd_i = mrd;   md_data_i = md;
        #1;
        if (rst) begin
            check_eq("md_ready_rst", md_ready_o, 0);
            m_fifo.delete();
            m_ovf = 1'b0; m_rd = '0; m_data = '0;
            exp_q.push_back(38'd0);
        end else begin
            check_eq("md_ready", md_ready_o, !av && m_fifo.size() == 0 && !lv);
            win = 1'b0; bypass = 1'b0; wrd = '0; wd = '0;
            lw = model_ext(ld, f3, off);
            if (av) begin
                win = 1'b1; wrd = ard; wd = ad;
            end else if (m_fifo.size() != 0) begin
                {wrd, wd} = m_fifo.pop_front();
                win = 1'b1;
            end else if (lv) begin
                win = 1'b1; wrd = lrd; wd = lw; bypass = 1'b1;
            end else if (mv) begin
                win = 1'b1; wrd = mrd; wd = md;
            end
            if (lv && !bypass) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back({lrd, lw});
                else m_ovf = 1'b1;
            end
            if (win) begin
                m_rd = wrd; m_data = wd;
            end
            exp_q.push_back({win && (wrd != 5'd0), m_rd, m_data});
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("wb_write", reg_write_wb_o, e[37]);
        check_eq("wb_rd", reg_rd_wb_o, e[36:32]);
        check_eq("wb_data", reg_rd_data_wb_o, e[31:0]);
        check_eq("stall", stall_wb_o, m_fifo.size() >= DEPTH - 1);
        check_eq("overflow", overflow_err_o, m_ovf);
    endtask

    task automatic go(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [2:0] f3, input logic [1:0] off,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        step(1'b0, av, ard, ad, lv, lrd, ld, f3, off, mv, mrd, md);
    endtask

    task automatic idle();
        go(0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1'b1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1'b1;
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        load_valid_i = 0; load_rd_i = 0; load_data_i = 0;
        load_funct3_i = 0; load_offset_i = 0;
        md_valid_i = 0; md_rd_i = 0; md_data_i = 0;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();
        check_eq("reset_write", reg_write_wb_o, 0);

        // ALU only
        go(1, 5, 32'h1234, 0, 0, 0, 3'b010, 0, 0, 0, 0);
        check_eq("alu_rd", reg_rd_wb_o, 5);
        check_eq("alu_data", reg_rd_data_wb_o, 32'h1234);
        idle();
        check_eq("alu_idle", reg_write_wb_o, 0);

        // ALU and load collision
        go(1, 3, 32'hA, 1, 4, 32'hB, 3'b010, 0, 0, 0, 0);
        check_eq("coll_first", reg_rd_wb_o, 3);
        idle();
        check_eq("coll_second", reg_rd_wb_o, 4);
        check_eq("coll_second_data", reg_rd_data_wb_o, 32'hB);

        // Extension
        go(0, 0, 0, 1, 7, 32'h0000_8000, 3'b000, 2'd1, 0, 0, 0);
`ifdef WB_LOAD_EXTEND_EN
        check_eq("lb_ext", reg_rd_data_wb_o, 32'hFFFF_FF80);
`else
        check_eq("lb_raw", reg_rd_data_wb_o, 32'h0000_8000);
`endif
        go(0, 0, 0, 1, 8, 32'h8001_0000, 3'b101, 2'd2, 0, 0, 0);
`ifdef WB_LOAD_EXTEND_EN
        check_eq("lhu_ext", reg_rd_data_wb_o, 32'h0000_8001);
`else
        check_eq("lhu_raw", reg_rd_data_wb_o, 32'h8001_0000);
`endif

        // Mul/div and x0 load
        go(0, 0, 0, 0, 0, 0, 3'b010, 0, 1, 9, 32'h55);
        check_eq("md_write", reg_write_wb_o, 1);
        go(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 3'b010, 0, 0, 0, 0);
        check_eq("x0_nowrite", reg_write_wb_o, 0);
        check_eq("x0_nostall", stall_wb_o, 0);

        // Fill, stall, overflow
        go(1, 1, 32'h11, 1, 10, 32'h100, 3'b010, 0, 0, 0, 0);
        check_eq("stall_n1", stall_wb_o, 1);
        go(1, 2, 32'h22, 1, 11, 32'h101, 3'b010, 0, 0, 0, 0);
        go(1, 3, 32'h33, 1, 12, 32'h102, 3'b010, 0, 0, 0, 0);
        check_eq("ovf_set", overflow_err_o, 1);
        for (int i = 0; i < 4; i++) idle();
        check_eq("ovf_sticky", overflow_err_o, 1);

        // Reset with two buffered loads
        do_reset();
        go(1, 1, 32'h11, 1, 13, 32'h200, 3'b010, 0, 0, 0, 0);
        go(1, 2, 32'h22, 1, 14, 32'h201, 3'b010, 0, 0, 0, 0);
        step(1'b1, 1, 6, 32'h66, 1, 15, 32'h202, 3'b010, 0, 1, 16, 32'h77);
        check_eq("rst_mid_data", reg_rd_data_wb_o, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            check_eq("rst_no_drain", reg_write_wb_o, 0);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 40) == 0,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 3) == 0 && !stall_wb_o, 5'($urandom_range(0, 31)), $urandom,
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        end
        check_eq("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-back stage of the core. Collects finished results from three producers (in-order ALU/memory-stage path, data-memory load responses, long-latency mul/div unit) and issues at most one register write per cycle to `register_file` through `reg_write_wb`/`reg_rd_wb`/`reg_rd_data_wb`. Load responses cannot be back-pressured, so losers are held in a small FIFO. A stall is raised to the pipeline controller before that FIFO can overflow.

## Interface
Parameters:
- `LOAD_FIFO_DEPTH`, 2: pending-load entries; power of two, ≥2.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `alu_valid_i` in 1: non-load result valid; always accepted.
- `alu_rd_i` in 5: destination register.
- `alu_data_i` in 32: result.
- `load_valid_i` in 1: load response valid; no ready, never dropped.
- `load_rd_i` in 5: destination register.
- `load_data_i` in 32: raw aligned memory word.
- `load_funct3_i` in 3: load type.
- `load_offset_i` in 2: byte address bits [1:0].
- `md_valid_i` in 1: mul/div result valid.
- `md_rd_i` in 5: destination register.
- `md_data_i` in 32: result.
- `md_ready_o` out 1: mul/div result accepted this cycle when `md_valid_i & md_ready_o`.
- `reg_write_wb_o` out 1: register write enable (to `register_file`).
- `reg_rd_wb_o` out 5: write address.
- `reg_rd_data_wb_o` out 32: write data.
- `stall_wb_o` out 1: to pipeline controller; stop issuing loads.
- `overflow_err_o` out 1: sticky; load arrived with FIFO full.

## Operation
- One winner per cycle, fixed priority: ALU > FIFO head > fresh load (bypass, FIFO empty only) > mul/div.
- A fresh load that does not win is pushed into the FIFO in the same cycle. This includes the case where the FIFO head wins that cycle, in which case push and pop are simultaneous and the count is unchanged.
- `md_ready_o` is combinational and equals `!alu_valid_i && fifo_empty && !load_valid_i`.
- A winning `rd == 0` is consumed but not written: `reg_write_wb_o` stays 0 that cycle.
- Load extension is applied before FIFO push. The FIFO stores final data, not raw data.
- `stall_wb_o = (count >= LOAD_FIFO_DEPTH-1)`. This keeps one slot free for a load already in flight.
- Load arriving with `count == LOAD_FIFO_DEPTH` and no pop that cycle:
  - the load is dropped;
  - `overflow_err_o` is set and held until reset.
- FIFO pointers wrap modulo `LOAD_FIFO_DEPTH`. Count width is `$clog2(DEPTH)+1`.

## Timing
- A winner in cycle N drives `reg_write_wb_o`/`reg_rd_wb_o`/`reg_rd_data_wb_o` from registers in cycle N+1. Latency is 1.
- In a cycle with no winner, `reg_write_wb_o = 0`, and address and data hold their last values.
- ALU and load valid in the same cycle N: ALU writes at N+1, the load (from the FIFO) at N+2.
- `stall_wb_o` is registered-count based. It changes the cycle after the push/pop that crosses the threshold.
- Reset (any cycle, including with FIFO non-empty):
  - FIFO emptied;
  - `reg_write_wb_o = 0`, `reg_rd_wb_o = 0`, `reg_rd_data_wb_o = 0`;
  - `stall_wb_o = 0`, `overflow_err_o = 0`.
  - While `rst_i` is high, `md_ready_o = 0` and inputs are ignored.

## Configuration
- `WB_LOAD_EXTEND_EN` defined:
  - `load_funct3_i`/`load_offset_i` select the byte or halfword from `load_data_i`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Halfword uses `offset[1]`.
- `WB_LOAD_EXTEND_EN` undefined:
  - `load_data_i` is written unchanged; funct3/offset are ignored.
  - Extension is then the memory stage's job.

## Structure
- Shared package/header:
  - load funct3 constants: LB=000, LH=001, LW=010, LBU=100, LHU=101;
  - the default FIFO depth.
- Sub-module `wb_load_fifo`:
  - {rd[4:0], data[31:0]} entries;
  - simultaneous push/pop;
  - count, full, empty outputs.
- Arbitration, extension and output registers live in the top module.

## Test plan
- ALU only: `alu_valid_i=1`, rd=5, data=0x1234 at N → `reg_write_wb_o=1`, rd=5, data=0x1234 at N+1; otherwise `reg_write_wb_o=0`.
- Collision: ALU (rd=3, 0xA) and load LW (rd=4, 0xB) at N → rd=3 at N+1, rd=4 at N+2; `md_ready_o=0` at N and N+1.
- Extension (macro on):
  - LB, offset 1, data 0x0000_8000 → 0xFFFF_FF80;
  - LHU, offset 2, data 0x8001_0000 → 0x0000_8001.
  - Macro off: the same LB stimulus → 0x0000_8000.
- Fill/stall (depth 2): ALU valid every cycle, loads at N and N+1.
  - `stall_wb_o=1` from N+1;
  - a third load at N+2 → `overflow_err_o=1`, sticky.
- rd=0: load to x0 with data 0xFFFF_FFFF → consumed, `reg_write_wb_o` stays 0, FIFO count unchanged.
- Reset mid-operation: FIFO holding 2 entries, `rst_i=1` for one cycle → next cycle all outputs 0, and no buffered entry is ever written.
